// File: rtl/tpram_rd_streamer_pkg.sv
// tpram_pkg
// Shared definitions for the TPRAM read streamer: wrapper read-mode
// encodings, the streamer state type, and small helpers that turn a mode
// into an address step, an address alignment and an element width.
// No ports (package).

package tpram_pkg;

    // Read-mode encodings understood by the TPRAM wrapper read port.
    localparam logic [1:0] DWORD = 2'b00;
    localparam logic [1:0] WORD  = 2'b01;
    localparam logic [1:0] BYTE  = 2'b10;
    localparam logic [1:0] RESV  = 2'b11;

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        RUN   = 2'd1,
        DRAIN = 2'd2
    } state_e;

    // RESV must never reach the wrapper: it asynchronously clears the
    // wrapper's lane-select register, so it is folded onto DWORD.
    function automatic logic [1:0] map_mode(input logic [1:0] mode);
        return (mode == RESV) ? DWORD : mode;
    endfunction

    // Bytes consumed per read.
    function automatic logic [2:0] step_size(input logic [1:0] mode);
        case (mode)
            BYTE:    return 3'd1;
            WORD:    return 3'd2;
            default: return 3'd4;
        endcase
    endfunction

    // Clears the address bits below the element size.
    function automatic logic [11:0] align_addr(input logic [1:0] mode,
                                               input logic [11:0] addr);
        case (mode)
            BYTE:    return addr;
            WORD:    return {addr[11:1], 1'b0};
            default: return {addr[11:2], 2'b00};
        endcase
    endfunction

    // The wrapper already rotates the element into the low lanes; only the
    // unused upper lanes need clearing.
    function automatic logic [31:0] widen(input logic [1:0] mode,
                                          input logic [31:0] data);
        case (mode)
            BYTE:    return {24'h0, data[7:0]};
            WORD:    return {16'h0, data[15:0]};
            default: return data;
        endcase
    endfunction

endpackage

// File: rtl/tpram_rd_fifo.sv
// tpram_rd_fifo
// Small synchronous FIFO holding streamed elements (data + last flag).
// Flush has priority over push and pop and empties the FIFO in one edge.
// Ports:
//   clk_i, rst_ni  clock, synchronous active-low reset
//   flush_i        discard all entries
//   push_i/wdata_i write one entry
//   pop_i          remove the head entry
//   rdata_o        head entry (valid when !empty_o)
//   count_o        current occupancy
//   full_o/empty_o occupancy flags

module tpram_rd_fifo #(
    parameter int DEPTH = 2,
    parameter int WIDTH = 33,
    parameter int CNT_W = $clog2(DEPTH + 1)
) (
    input  logic             clk_i,
    input  logic             rst_ni,
    input  logic             flush_i,
    input  logic             push_i,
    input  logic [WIDTH-1:0] wdata_i,
    input  logic             pop_i,
    output logic [WIDTH-1:0] rdata_o,
    output logic [CNT_W-1:0] count_o,
    output logic             full_o,
    output logic             empty_o
);

    localparam int PTR_W = $clog2(DEPTH);

    logic [WIDTH-1:0] mem_q [DEPTH];
    logic [PTR_W-1:0] wr_ptr_q, wr_ptr_d;
    logic [PTR_W-1:0] rd_ptr_q, rd_ptr_d;
    logic [CNT_W-1:0] count_q, count_d;
    logic             do_push;
    logic             do_pop;

    // Pointers wrap explicitly so DEPTH need not be a power of two.
    function automatic logic [PTR_W-1:0] ptr_inc(input logic [PTR_W-1:0] p);
        return (p == PTR_W'(DEPTH - 1)) ? '0 : p + PTR_W'(1);
    endfunction

    assign full_o  = (count_q == CNT_W'(DEPTH));
    assign empty_o = (count_q == '0);
    assign count_o = count_q;
    assign rdata_o = mem_q[rd_ptr_q];

    // A push into a full FIFO is only accepted when a pop frees a slot on
    // the same edge.
    assign do_pop  = pop_i && !empty_o && !flush_i;
    assign do_push = push_i && (!full_o || do_pop) && !flush_i;

    always_comb begin
        wr_ptr_d = wr_ptr_q;
        rd_ptr_d = rd_ptr_q;
        count_d  = count_q;
        if (flush_i) begin
            wr_ptr_d = '0;
            rd_ptr_d = '0;
            count_d  = '0;
        end else begin
            if (do_push) wr_ptr_d = ptr_inc(wr_ptr_q);
            if (do_pop)  rd_ptr_d = ptr_inc(rd_ptr_q);
            case ({do_push, do_pop})
                2'b10:   count_d = count_q + CNT_W'(1);
                2'b01:   count_d = count_q - CNT_W'(1);
                default: count_d = count_q;
            endcase
        end
    end

    always_ff @(posedge clk_i) begin
        if (!rst_ni) begin
            wr_ptr_q <= '0;
            rd_ptr_q <= '0;
            count_q  <= '0;
        end else begin
            wr_ptr_q <= wr_ptr_d;
            rd_ptr_q <= rd_ptr_d;
            count_q  <= count_d;
        end
    end

    always_ff @(posedge clk_i) begin
        if (do_push) mem_q[wr_ptr_q] <= wdata_i;
    end

endmodule

// File: rtl/tpram_rd_streamer.sv
// tpram_rd_streamer
// Read-side initiator for the eFPGA TPRAM wrapper. Takes one command
// (base byte address, element count, mode), walks the wrapper's 12-bit
// byte-addressed read port, and streams zero-extended elements out on a
// valid/ready interface with a last flag.
// Ports:
//   EFPGA_TPRAM_R_CLK, EFPGA_RST_N   clock, synchronous active-low reset
//   CMD_VALID/CMD_READY/CMD_ADDR/CMD_LEN/CMD_MODE  command handshake
//   ABORT                            cancel the running command
//   EFPGA_TPRAM_R_ADDR/_R_MODE       wrapper read address and mode
//   TPRAM_EFPGA_R_DATA               rotated read data (one cycle latency)
//   DOUT_VALID/READY/DATA/LAST       element stream
//   BUSY, DONE                       status; DONE pulses on normal completion

module tpram_rd_streamer
    import tpram_pkg::*;
#(
    parameter int FIFO_DEPTH = 2,
    parameter int LEN_W      = 13
) (
    input  logic             EFPGA_TPRAM_R_CLK,
    input  logic             EFPGA_RST_N,
    input  logic             CMD_VALID,
    output logic             CMD_READY,
    input  logic [11:0]      CMD_ADDR,
    input  logic [LEN_W-1:0] CMD_LEN,
    input  logic [1:0]       CMD_MODE,
    input  logic             ABORT,
    output logic [11:0]      EFPGA_TPRAM_R_ADDR,
    output logic [1:0]       EFPGA_TPRAM_R_MODE,
    input  logic [31:0]      TPRAM_EFPGA_R_DATA,
    output logic             DOUT_VALID,
    input  logic             DOUT_READY,
    output logic [31:0]      DOUT_DATA,
    output logic             DOUT_LAST,
    output logic             BUSY,
    output logic             DONE
);

    localparam int CNT_W = $clog2(FIFO_DEPTH + 1);
    localparam int OCC_W = CNT_W + 1;

    state_e           state_q, state_d;
    logic [11:0]      addr_q, addr_d;
    logic [1:0]       mode_q, mode_d;
    logic [LEN_W-1:0] remaining_q, remaining_d;
    logic             inflight_q, inflight_d;
    logic             inflight_last_q, inflight_last_d;

    logic             abort_active;
    logic             fifo_push, fifo_pop;
    logic [32:0]      fifo_rdata;
    logic [CNT_W-1:0] fifo_count;
    logic             fifo_full, fifo_empty;
    logic [OCC_W-1:0] occ_after;
    logic             issue;

    assign abort_active = ABORT && (state_q != IDLE);
    assign fifo_pop     = DOUT_VALID && DOUT_READY && !abort_active;
    assign fifo_push    = inflight_q && !abort_active;

    // Occupancy once this edge settles, counting the read already in flight;
    // a new read may only go out if its data is guaranteed a slot.
    assign occ_after = {1'b0, fifo_count} + OCC_W'(inflight_q) - OCC_W'(fifo_pop);
    assign issue     = (state_q == RUN) && (remaining_q != '0) && !abort_active
                       && (occ_after < OCC_W'(FIFO_DEPTH));

    tpram_rd_fifo #(
        .DEPTH (FIFO_DEPTH),
        .WIDTH (33),
        .CNT_W (CNT_W)
    ) u_fifo (
        .clk_i   (EFPGA_TPRAM_R_CLK),
        .rst_ni  (EFPGA_RST_N),
        .flush_i (abort_active),
        .push_i  (fifo_push),
        .wdata_i ({inflight_last_q, widen(mode_q, TPRAM_EFPGA_R_DATA)}),
        .pop_i   (fifo_pop),
        .rdata_o (fifo_rdata),
        .count_o (fifo_count),
        .full_o  (fifo_full),
        .empty_o (fifo_empty)
    );

    // Next-state logic: command capture, read issue and completion.
    always_comb begin
        state_d         = state_q;
        addr_d          = addr_q;
        mode_d          = mode_q;
        remaining_d     = remaining_q;
        inflight_d      = 1'b0;
        inflight_last_d = 1'b0;
        DONE            = 1'b0;

        case (state_q)
            IDLE: begin
                if (CMD_VALID) begin
                    mode_d      = map_mode(CMD_MODE);
                    addr_d      = align_addr(map_mode(CMD_MODE), CMD_ADDR);
                    remaining_d = CMD_LEN;
                    // An empty command completes through DRAIN with nothing to wait for.
                    state_d     = (CMD_LEN == '0) ? DRAIN : RUN;
                end
            end
            RUN: begin
                if (abort_active) begin
                    state_d     = IDLE;
                    remaining_d = '0;
                end else if (issue) begin
                    addr_d          = addr_q + {9'd0, step_size(mode_q)};
                    remaining_d     = remaining_q - LEN_W'(1);
                    inflight_d      = 1'b1;
                    inflight_last_d = (remaining_q == LEN_W'(1));
                    if (remaining_q == LEN_W'(1)) state_d = DRAIN;
                end
            end
            DRAIN: begin
                if (abort_active) begin
                    state_d = IDLE;
                end else if (fifo_empty && !inflight_q) begin
                    state_d = IDLE;
                    DONE    = 1'b1;
                end
            end
            default: state_d = IDLE;
        endcase
    end

    always_ff @(posedge EFPGA_TPRAM_R_CLK) begin
        if (!EFPGA_RST_N) begin
            state_q         <= IDLE;
            addr_q          <= '0;
            mode_q          <= DWORD;
            remaining_q     <= '0;
            inflight_q      <= 1'b0;
            inflight_last_q <= 1'b0;
        end else begin
            state_q         <= state_d;
            addr_q          <= addr_d;
            mode_q          <= mode_d;
            remaining_q     <= remaining_d;
            inflight_q      <= inflight_d;
            inflight_last_q <= inflight_last_d;
        end
    end

    assign CMD_READY          = (state_q == IDLE);
    assign BUSY               = (state_q != IDLE);
    assign EFPGA_TPRAM_R_ADDR = addr_q;
    assign EFPGA_TPRAM_R_MODE = mode_q;
    assign DOUT_VALID         = !fifo_empty;
    // Stale entries left behind by a flush are masked so an idle stream reads as zero.
    assign DOUT_DATA          = fifo_empty ? 32'h0 : fifo_rdata[31:0];
    assign DOUT_LAST          = !fifo_empty && fifo_rdata[32];

    // The issue rule reserves a slot for every read in flight.
    assert property (@(posedge EFPGA_TPRAM_R_CLK) disable iff (!EFPGA_RST_N)
                     !(fifo_push && fifo_full && !fifo_pop));

endmodule

// File: tb/tb_tpram_rd_streamer.sv
// tb_tpram_rd_streamer
// Directed bench for tpram_rd_streamer with a one-cycle-latency wrapper
// read model. Memory byte i holds i[7:0] except bytes 0x005..0x007, which
// hold A1, B2, C3.

module tb_tpram_rd_streamer;

    logic        clock;
    logic        rstN;
    logic        cmdValid;
    logic        cmdReady;
    logic [11:0] cmdAddr;
    logic [12:0] cmdLen;
    logic [1:0]  cmdMode;
    logic        abort;
    logic [11:0] rAddr;
    logic [1:0]  rMode;
    logic [31:0] rData;
    logic        doutValid;
    logic        doutReady;
    logic [31:0] doutData;
    logic        doutLast;
    logic        busy;
    logic        done;

    logic [7:0]  mem [4096];
    logic [11:0] expAddr [4];
    logic [31:0] expData [4];
    logic [31:0] expWord [8];

    int checkCount = 0;
    int errorCount = 0;

    tpram_rd_streamer #(
        .FIFO_DEPTH (2),
        .LEN_W      (13)
    ) dut (
        .EFPGA_TPRAM_R_CLK  (clock),
        .EFPGA_RST_N        (rstN),
        .CMD_VALID          (cmdValid),
        .CMD_READY          (cmdReady),
        .CMD_ADDR           (cmdAddr),
        .CMD_LEN            (cmdLen),
        .CMD_MODE           (cmdMode),
        .ABORT              (abort),
        .EFPGA_TPRAM_R_ADDR (rAddr),
        .EFPGA_TPRAM_R_MODE (rMode),
        .TPRAM_EFPGA_R_DATA (rData),
        .DOUT_VALID         (doutValid),
        .DOUT_READY         (doutReady),
        .DOUT_DATA          (doutData),
        .DOUT_LAST          (doutLast),
        .BUSY               (busy),
        .DONE               (done)
    );

    initial clock = 1'b0;
    always #5 clock = ~clock;

    // Wrapper model: registers the address, returns the dword starting at
    // that byte rotated into the low lanes; upper lanes carry neighbours.
    always @(posedge clock) begin
        rData <= {mem[rAddr + 12'd3], mem[rAddr + 12'd2], mem[rAddr + 12'd1], mem[rAddr]};
    end

    task automatic tick();
        @(posedge clock);
        #1;
    endtask

    task automatic checkOutput(input string tag, input logic [31:0] observed,
                               input logic [31:0] expected);
        checkCount++;
        assert (observed === expected) else begin
            errorCount++;
            $error("[TB] FAIL %s: observed=%h expected=%h", tag, observed, expected);
        end
    endtask

    // Presents one command for one edge; the streamer must be idle.
    task automatic applyStimulus(input logic [11:0] addr, input logic [12:0] len,
                                 input logic [1:0] mode);
        checkOutput("cmd_ready before accept", 32'(cmdReady), 32'd1);
        cmdAddr  = addr;
        cmdLen   = len;
        cmdMode  = mode;
        cmdValid = 1'b1;
        tick();
        cmdValid = 1'b0;
    endtask

    task automatic checkBeat(input string tag, input logic [31:0] data, input logic last);
        checkOutput({tag, " valid"}, 32'(doutValid), 32'd1);
        checkOutput({tag, " data"}, doutData, data);
        checkOutput({tag, " last"}, 32'(doutLast), 32'(last));
    endtask

    // Four-element burst with doutReady held high, starting the cycle after accept.
    task automatic checkBurst4(input string tag);
        checkOutput({tag, " raddr0"}, 32'(rAddr), 32'(expAddr[0]));
        checkOutput({tag, " no early valid"}, 32'(doutValid), 32'd0);
        tick();
        checkOutput({tag, " raddr1"}, 32'(rAddr), 32'(expAddr[1]));
        checkOutput({tag, " no early valid"}, 32'(doutValid), 32'd0);
        tick();
        checkOutput({tag, " raddr2"}, 32'(rAddr), 32'(expAddr[2]));
        checkBeat({tag, " beat0"}, expData[0], 1'b0);
        tick();
        checkOutput({tag, " raddr3"}, 32'(rAddr), 32'(expAddr[3]));
        checkBeat({tag, " beat1"}, expData[1], 1'b0);
        tick();
        checkBeat({tag, " beat2"}, expData[2], 1'b0);
        checkOutput({tag, " no done yet"}, 32'(done), 32'd0);
        tick();
        checkBeat({tag, " beat3"}, expData[3], 1'b1);
        tick();
        checkOutput({tag, " done"}, 32'(done), 32'd1);
        checkOutput({tag, " valid after last"}, 32'(doutValid), 32'd0);
        checkOutput({tag, " cmd_ready in done"}, 32'(cmdReady), 32'd0);
        tick();
        checkOutput({tag, " done cleared"}, 32'(done), 32'd0);
        checkOutput({tag, " idle"}, 32'(busy), 32'd0);
    endtask

    task automatic checkResetValues(input string tag);
        checkOutput({tag, " cmd_ready"}, 32'(cmdReady), 32'd1);
        checkOutput({tag, " busy"}, 32'(busy), 32'd0);
        checkOutput({tag, " done"}, 32'(done), 32'd0);
        checkOutput({tag, " dout_valid"}, 32'(doutValid), 32'd0);
        checkOutput({tag, " dout_last"}, 32'(doutLast), 32'd0);
        checkOutput({tag, " dout_data"}, doutData, 32'd0);
        checkOutput({tag, " r_addr"}, 32'(rAddr), 32'd0);
        checkOutput({tag, " r_mode"}, 32'(rMode), 32'd0);
    endtask

    initial begin
        logic [23:0] readyPat;
        logic [31:0] prevData;
        logic        stalledPrev;
        int          got;
        int          cyc;

        for (int i = 0; i < 4096; i++) mem[i] = i[7:0];
        mem[5] = 8'hA1;
        mem[6] = 8'hB2;
        mem[7] = 8'hC3;

        rstN      = 1'b0;
        cmdValid  = 1'b0;
        cmdAddr   = '0;
        cmdLen    = '0;
        cmdMode   = 2'b00;
        abort     = 1'b0;
        doutReady = 1'b1;
        tick();
        tick();
        checkResetValues("reset");
        rstN = 1'b1;
        tick();

        $display("[TB] dword burst from 0x010");
        applyStimulus(12'h010, 13'd4, 2'b00);
        expAddr = '{12'h010, 12'h014, 12'h018, 12'h01C};
        expData = '{32'h13121110, 32'h17161514, 32'h1B1A1918, 32'h1F1E1D1C};
        checkBurst4("dword");

        $display("[TB] byte burst from 0x005");
        applyStimulus(12'h005, 13'd3, 2'b10);
        checkOutput("byte r_mode", 32'(rMode), 32'd2);
        checkOutput("byte raddr0", 32'(rAddr), 32'h005);
        tick();
        checkOutput("byte raddr1", 32'(rAddr), 32'h006);
        tick();
        checkBeat("byte beat0", 32'h000000A1, 1'b0);
        tick();
        checkBeat("byte beat1", 32'h000000B2, 1'b0);
        checkOutput("byte r_mode held", 32'(rMode), 32'd2);
        tick();
        checkBeat("byte beat2", 32'h000000C3, 1'b1);
        tick();
        checkOutput("byte done", 32'(done), 32'd1);
        tick();

        $display("[TB] word burst with backpressure");
        expWord = '{32'h0100, 32'h0302, 32'h0504, 32'h0706,
                    32'h0908, 32'h0B0A, 32'h0D0C, 32'h0F0E};
        readyPat    = 24'b1111_0110_1100_1011_0011_1001;
        stalledPrev = 1'b0;
        prevData    = '0;
        got         = 0;
        cyc         = 0;
        applyStimulus(12'h101, 13'd8, 2'b01);
        checkOutput("word aligned raddr", 32'(rAddr), 32'h100);
        while (got < 8 && cyc < 80) begin
            doutReady = (cyc < 24) ? readyPat[cyc] : 1'b1;
            if (doutValid) begin
                if (stalledPrev) checkOutput("word stable while stalled", doutData, prevData);
                if (doutReady) begin
                    checkOutput("word data", doutData, expWord[got]);
                    checkOutput("word last", 32'(doutLast), 32'(got == 7));
                    got++;
                end
                stalledPrev = !doutReady;
                prevData    = doutData;
            end else begin
                stalledPrev = 1'b0;
            end
            tick();
            cyc++;
        end
        checkOutput("word element count", 32'(got), 32'd8);
        checkOutput("word done", 32'(done), 32'd1);
        checkOutput("word no extra beat", 32'(doutValid), 32'd0);
        doutReady = 1'b1;
        tick();

        $display("[TB] wrap and reserved mode");
        applyStimulus(12'hFF8, 13'd4, 2'b11);
        checkOutput("resv r_mode", 32'(rMode), 32'd0);
        expAddr = '{12'hFF8, 12'hFFC, 12'h000, 12'h004};
        expData = '{32'hFBFAF9F8, 32'hFFFEFDFC, 32'h03020100, 32'hC3B2A104};
        checkBurst4("wrap");

        $display("[TB] empty command");
        applyStimulus(12'h020, 13'd0, 2'b00);
        checkOutput("len0 done", 32'(done), 32'd1);
        checkOutput("len0 valid", 32'(doutValid), 32'd0);
        checkOutput("len0 cmd_ready", 32'(cmdReady), 32'd0);
        tick();
        checkOutput("len0 done cleared", 32'(done), 32'd0);
        checkOutput("len0 cmd_ready back", 32'(cmdReady), 32'd1);
        checkOutput("len0 still no valid", 32'(doutValid), 32'd0);

        $display("[TB] abort on third beat");
        applyStimulus(12'h040, 13'd16, 2'b00);
        tick();
        tick();
        checkBeat("abort beat0", 32'h43424140, 1'b0);
        tick();
        tick();
        checkBeat("abort beat2", 32'h4B4A4948, 1'b0);
        abort = 1'b1;
        checkOutput("abort no done", 32'(done), 32'd0);
        tick();
        abort = 1'b0;
        checkOutput("abort idle", 32'(busy), 32'd0);
        checkOutput("abort cmd_ready", 32'(cmdReady), 32'd1);
        checkOutput("abort valid dropped", 32'(doutValid), 32'd0);
        checkOutput("abort done", 32'(done), 32'd0);
        tick();
        checkOutput("abort inflight dropped", 32'(doutValid), 32'd0);
        checkOutput("abort still no done", 32'(done), 32'd0);
        applyStimulus(12'h080, 13'd2, 2'b00);
        checkOutput("fresh no early valid", 32'(doutValid), 32'd0);
        tick();
        checkOutput("fresh no early valid 2", 32'(doutValid), 32'd0);
        tick();
        checkBeat("fresh beat0", 32'h83828180, 1'b0);
        tick();
        checkBeat("fresh beat1", 32'h87868584, 1'b1);
        tick();
        checkOutput("fresh done", 32'(done), 32'd1);
        tick();

        $display("[TB] reset mid-stream");
        applyStimulus(12'h0C0, 13'd16, 2'b10);
        tick();
        tick();
        tick();
        checkOutput("midreset r_mode before", 32'(rMode), 32'd2);
        checkOutput("midreset streaming", 32'(doutValid), 32'd1);
        rstN = 1'b0;
        tick();
        checkResetValues("midreset");
        rstN = 1'b1;
        tick();
        checkOutput("post reset idle", 32'(busy), 32'd0);

        $display("Simulation finished: %0d checks, %0d errors", checkCount, errorCount);
        $finish;
    end

endmodule
